seq_shifter: RTL
================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; legal values are powers of two, 4 to 64.
REQ-002 SHALL have localparam AMTW = log2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, the request to begin an operation.
REQ-006 SHALL have port din, input, WIDTH, the operand; din[WIDTH-1] is the MSB.
REQ-007 SHALL have port amt, input, AMTW, the shift distance, 0 to WIDTH-1.
REQ-008 SHALL have port mode, input, 2, the operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL (rotate left).
REQ-009 SHALL have port busy, output, 1, high while an operation is shifting.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port dout, output, WIDTH, the result register.
REQ-012 SHALL have port cout, output, 1, the last bit shifted or rotated out.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL accept start only when busy=0, i.e. in IDLE or DONE.
- On acceptance, dout<=din, cout<=0, and the counter<=amt; mode and amt are latched.
REQ-015 SHALL ignore start while busy=1; it has no effect on state, counter, dout or latched mode.
REQ-016 On acceptance, SHALL go to DONE if amt=0, else to SHIFT.
REQ-017 In SHIFT, SHALL shift dout by exactly one bit per clock and decrement the counter, using the latched mode:
- LSL: dout<={dout[W-2:0],0}, cout<=dout[W-1].
- LSR: dout<={0,dout[W-1:1]}, cout<=dout[0].
- ASR: dout<={dout[W-1],dout[W-1:1]}, cout<=dout[0].
- ROL: dout<={dout[W-2:0],dout[W-1]}, cout<=dout[W-1].
REQ-018 SHALL leave SHIFT for DONE on the edge performing the final shift (counter 1->0).
REQ-019 SHALL make done high exactly while in DONE, for one cycle, then go to IDLE unless start is accepted in that cycle.
REQ-020 Latency: SHALL make done high in the cycle following edge E+amt, where E is the accepting edge.
- amt=0 gives one cycle of latency; amt=WIDTH-1 gives WIDTH cycles.
REQ-021 SHALL drive busy=1 iff state=SHIFT; busy and done SHALL never both be high.
REQ-022 SHALL hold dout and cout stable from the done cycle until the next accepted start.
REQ-023 A start accepted in DONE SHALL both pulse done for the finishing operation and load the new operand on the same edge, giving back-to-back throughput.
REQ-024 Any change to din, amt or mode after acceptance SHALL NOT affect the operation in progress.
REQ-025 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-026 While rst=1, SHALL force state=IDLE, counter=0, dout=0, cout=0, busy=0, done=0, independent of clk.
REQ-027 Reset asserted during SHIFT or DONE SHALL abort the operation with no done pulse.
- The first start sampled after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 Reset check: assert rst asynchronously mid-SHIFT -> all outputs 0 immediately, no done pulse; then start, din=0x01, amt=1, LSL -> dout=0x02.
REQ-029 Mode sweep, din=0xB4, amt=3:
- LSL -> dout=0xA0, cout=1.
- LSR -> dout=0x16, cout=1.
- ASR -> dout=0xF6, cout=1.
- ROL -> dout=0xA5, cout=1.
- For each, done rises exactly 3 cycles after the done-cycle timing for amt=0.
REQ-030 Boundaries:
- amt=0, din=0x5A, ROL -> done in first cycle after acceptance, dout=0x5A, cout=0, busy never high.
- amt=7, din=0x80, ASR -> dout=0xFF after 8 cycles.
REQ-031 Start while busy: start pulsed with din=0xFF mid-operation (din=0x0F, amt=4, LSL) -> ignored; dout=0xF0, one done pulse only.
REQ-032 Back-to-back: start held high with din=0x03, amt=2, LSL, then din=0x81, amt=1, ROL -> done pulses with dout=0x0C, then dout=0x03, with no idle cycle between.
REQ-033 Operand stability: change din/amt/mode every cycle during SHIFT -> result matches a software model of the values latched at acceptance, checked over 1000 random operations.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-free shifter. An accepted operation loads the
// operand and then shifts the result register by one bit per clock until the
// requested distance has been covered. The mode is one of LSL, LSR, ASR or ROL.
// A one-cycle done pulse marks the result. A new operation may be accepted in
// that same done cycle, which gives back-to-back throughput.
module seq_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   amt,
    input  logic [1:0]                 mode,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           dout,
    output logic                       cout
);

    localparam int AMTW = $clog2(WIDTH);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state_reg;
    logic [AMTW-1:0]   cnt_reg;
    logic [1:0]        mode_reg;
    logic [WIDTH-1:0]  dout_reg;
    logic              cout_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [WIDTH-1:0]  shift_dout;
    logic              shift_cout;
    logic              accept;

    // Start is only honoured when not shifting, i.e. in IDLE or DONE.
    assign accept = start && (state_reg != SHIFT);

    // One-bit step of the result register under the latched mode.
    always_comb begin
        shift_dout = dout_reg;
        shift_cout = cout_reg;
        case (mode_reg)
            MODE_LSL: begin
                shift_dout = {dout_reg[WIDTH-2:0], 1'b0};
                shift_cout = dout_reg[WIDTH-1];
            end
            MODE_LSR: begin
                shift_dout = {1'b0, dout_reg[WIDTH-1:1]};
                shift_cout = dout_reg[0];
            end
            MODE_ASR: begin
                shift_dout = {dout_reg[WIDTH-1], dout_reg[WIDTH-1:1]};
                shift_cout = dout_reg[0];
            end
            MODE_ROL: begin
                shift_dout = {dout_reg[WIDTH-2:0], dout_reg[WIDTH-1]};
                shift_cout = dout_reg[WIDTH-1];
            end
            default: begin
                shift_dout = dout_reg;
                shift_cout = cout_reg;
            end
        endcase
    end

    // Control FSM with registered busy/done, plus the datapath registers.
    // busy and done are set together with the next state, so they are
    // always equal to (state==SHIFT) and (state==DONE) respectively.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= MODE_LSL;
            dout_reg  <= '0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        dout_reg <= din;
                        cout_reg <= 1'b0;
                        cnt_reg  <= amt;
                        mode_reg <= mode;
                        if (amt == '0) begin
                            // Zero distance: result is the operand, finish next cycle.
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end else begin
                        // dout/cout hold their value until the next accepted start.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    dout_reg <= shift_dout;
                    cout_reg <= shift_cout;
                    cnt_reg  <= cnt_reg - AMTW'(1);
                    if (cnt_reg == AMTW'(1)) begin
                        // This edge performs the final shift.
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign dout = dout_reg;
    assign cout = cout_reg;

endmodule
